// File: rtl/mem_copy_master_if.sv
// Memory-port bus between the copy master and the data-memory / MMIO port.
interface mem_copy_master_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output bus_req, addr, we, wdata, input bus_gnt, rdata);
  modport slave  (input bus_req, addr, we, wdata, output bus_gnt, rdata);
endinterface

// File: rtl/mem_copy_master.sv
// Block copy initiator: moves len words src->dst, one read then one write per word,
// arbitrating for the memory port with bus_req/bus_gnt between words.
module mem_copy_master #(
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  mem_copy_master_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WAIT, S_WR, S_DONE} state_t;

  state_t           state, nxt;
  logic [31:0]      src_q, dst_q, data_q;
  logic [LEN_W-1:0] rem;
  logic [1:0]       cnt;
  logic             rd_last;

  // read data is valid in the last WAIT cycle
  assign rd_last = (cnt == 2'(RD_LAT - 1));

  // state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= nxt;
  end

  // address/count/data registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      src_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
      rem    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start && len != '0) begin
          src_q <= src & ~32'd3;
          dst_q <= dst & ~32'd3;
          rem   <= len;
        end
        S_RD: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 2'd1;
          if (rd_last) data_q <= bus.rdata;
        end
        S_WR: begin
          src_q <= src_q + 32'd4;
          dst_q <= dst_q + 32'd4;
          rem   <= rem - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // next state; grant is only looked at in REQ and at the end of a word
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = (len != '0) ? S_REQ : S_DONE;
      S_REQ:  if (bus.bus_gnt) nxt = S_RD;
      S_RD:   nxt = S_WAIT;
      S_WAIT: if (rd_last) nxt = S_WR;
      S_WR: begin
        if (rem == LEN_W'(1))  nxt = S_DONE;
        else if (bus.bus_gnt)  nxt = S_RD;
        else                   nxt = S_REQ;
      end
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // outputs decoded from state so reset clears them immediately
  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    bus.bus_req = (state == S_REQ) || (state == S_RD) || (state == S_WAIT) || (state == S_WR);
    bus.we      = (state == S_WR);
    bus.addr    = '0;
    bus.wdata   = '0;
    case (state)
      S_RD, S_WAIT: bus.addr = src_q;
      S_WR: begin
        bus.addr  = dst_q;
        bus.wdata = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench: two masters (RD_LAT=1 and RD_LAT=3) each on a small memory model.
module tb_mem_copy_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, start1, start2, gnt;
  logic [31:0] src_i, dst_i;
  logic [5:0]  len_i;
  logic        busy1, done1, busy2, done2;
  logic        ld_we, ld_sel;
  logic [7:0]  ld_a;
  logic [31:0] ld_d;

  mem_copy_master_if b1();
  mem_copy_master_if b2();
  assign b1.bus_gnt = gnt;
  assign b2.bus_gnt = gnt;

  mem_copy_master #(.RD_LAT(1), .LEN_W(6)) u1 (
    .clk(clk), .clr(clr), .start(start1), .src(src_i), .dst(dst_i), .len(len_i),
    .busy(busy1), .done(done1), .bus(b1.master));
  mem_copy_master #(.RD_LAT(3), .LEN_W(6)) u2 (
    .clk(clk), .clr(clr), .start(start2), .src(src_i), .dst(dst_i), .len(len_i),
    .busy(busy2), .done(done2), .bus(b2.master));

  // memory models: synchronous read with RD_LAT register stages, word index addr[9:2]
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] p1 [4];
  logic [31:0] p2 [4];
  always @(posedge clk) begin
    if (ld_we && !ld_sel) mem1[ld_a] <= ld_d;
    else if (b1.we)       mem1[b1.addr[9:2]] <= b1.wdata;
    if (ld_we && ld_sel)  mem2[ld_a] <= ld_d;
    else if (b2.we)       mem2[b2.addr[9:2]] <= b2.wdata;
    p1[0] <= mem1[b1.addr[9:2]];
    p2[0] <= mem2[b2.addr[9:2]];
    for (int i = 1; i < 4; i++) begin
      p1[i] <= p1[i-1];
      p2[i] <= p2[i-1];
    end
  end
  assign b1.rdata = p1[0];
  assign b2.rdata = p2[2];

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // per-cycle snapshots of one run, cycle 0 = start cycle
  logic        s_req [32];
  logic        s_we  [32];
  logic        s_done[32];
  logic        s_busy[32];
  logic [31:0] s_addr[32];
  logic [31:0] s_wd  [32];
  logic        gnt_s [32];

  task automatic snap(input bit sel, input int k);
    s_req[k]  = sel ? b2.bus_req : b1.bus_req;
    s_we[k]   = sel ? b2.we      : b1.we;
    s_done[k] = sel ? done2      : done1;
    s_busy[k] = sel ? busy2      : busy1;
    s_addr[k] = sel ? b2.addr    : b1.addr;
    s_wd[k]   = sel ? b2.wdata   : b1.wdata;
  endtask

  task automatic gnt_all1();
    for (int k = 0; k < 32; k++) gnt_s[k] = 1'b1;
  endtask

  task automatic ld(input bit sel, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_sel = sel; ld_a = a; ld_d = d; ld_we = 1'b1;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // pulse start in cycle 0 and record ncyc cycles; optional second start at rs_at
  task automatic run(input bit sel, input logic [31:0] s, input logic [31:0] d,
                     input logic [5:0] l, input int ncyc, input int rs_at);
    @(negedge clk);
    src_i = s; dst_i = d; len_i = l; gnt = gnt_s[0];
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    #1 snap(sel, 0);
    for (int k = 1; k < ncyc; k++) begin
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      if (k == rs_at) begin
        src_i = 32'h100; dst_i = 32'h200; len_i = 6'd7;
        if (sel) start2 = 1'b1; else start1 = 1'b1;
      end
      gnt = gnt_s[k];
      #1 snap(sel, k);
    end
    start1 = 1'b0; start2 = 1'b0;
  endtask

  function automatic int cnt_we(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(s_we[k]);
    return c;
  endfunction

  function automatic int cnt_req(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(s_req[k]);
    return c;
  endfunction

  function automatic int cnt_done(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(s_done[k]);
    return c;
  endfunction

  initial begin
    clr = 1'b1; start1 = 1'b0; start2 = 1'b0; gnt = 1'b1;
    src_i = '0; dst_i = '0; len_i = '0;
    ld_we = 1'b0; ld_sel = 1'b0; ld_a = '0; ld_d = '0;
    gnt_all1();
    #12;
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_req",  32'(b1.bus_req), 32'd0);
    check("rst_we",   32'(b1.we), 32'd0);
    check("rst_addr", b1.addr, 32'd0);
    check("rst_wd",   b1.wdata, 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // 1: basic 4-word copy, grant tied high
    for (int i = 0; i < 4; i++) ld(0, 8'(i), 32'hA0A0_0000 | i);
    run(0, 32'h00, 32'h40, 6'd4, 20, -1);
    check("t1_req_c1",  32'(s_req[1]), 32'd1);
    check("t1_we_c1",   32'(s_we[1]), 32'd0);
    check("t1_rd_req",  32'(s_req[2]), 32'd1);
    check("t1_rd_addr", s_addr[2], 32'h00);
    check("t1_wr0_we",  32'(s_we[4]), 32'd1);
    check("t1_wr0_a",   s_addr[4], 32'h40);
    check("t1_wr0_d",   s_wd[4], 32'hA0A0_0000);
    check("t1_wr1_a",   s_we[7] ? s_addr[7] : 32'hFFFF_FFFF, 32'h44);
    check("t1_wr2_a",   s_we[10] ? s_addr[10] : 32'hFFFF_FFFF, 32'h48);
    check("t1_wr3_a",   s_we[13] ? s_addr[13] : 32'hFFFF_FFFF, 32'h4C);
    check("t1_wr3_d",   s_wd[13], 32'hA0A0_0003);
    check("t1_nwe",     32'(cnt_we(20)), 32'd4);
    check("t1_done14",  32'(s_done[14]), 32'd1);
    check("t1_busy14",  32'(s_busy[14]), 32'd1);
    check("t1_busy15",  32'(s_busy[15]), 32'd0);
    check("t1_ndone",   32'(cnt_done(20)), 32'd1);
    for (int i = 0; i < 4; i++) check($sformatf("t1_ram%0d", 16 + i), mem1[16 + i], 32'hA0A0_0000 | i);

    // 2: len=0 finishes without touching the bus
    run(0, 32'h00, 32'h40, 6'd0, 6, -1);
    check("t2_done1", 32'(s_done[1]), 32'd1);
    check("t2_busy1", 32'(s_busy[1]), 32'd1);
    check("t2_nreq",  32'(cnt_req(6)), 32'd0);
    check("t2_nwe",   32'(cnt_we(6)), 32'd0);
    check("t2_ndone", 32'(cnt_done(6)), 32'd1);

    // 3: delayed grant, then grant dropped between words
    for (int k = 0; k < 4; k++) gnt_s[k] = 1'b0;
    gnt_s[7] = 1'b0; gnt_s[8] = 1'b0;
    run(0, 32'h08, 32'h60, 6'd2, 16, -1);
    gnt_all1();
    check("t3_req_c3",  32'(s_req[3]), 32'd1);
    check("t3_addr_c3", s_addr[3], 32'h0);
    check("t3_we_c3",   32'(s_we[3]), 32'd0);
    check("t3_addr_c4", s_addr[4], 32'h0);
    check("t3_rd_c5",   s_addr[5], 32'h08);
    check("t3_wr0",     s_we[7] ? s_wd[7] : 32'hFFFF_FFFF, 32'hA0A0_0002);
    check("t3_req_c8",  32'(s_req[8]), 32'd1);
    check("t3_addr_c9", s_addr[9], 32'h0);
    check("t3_rd_c10",  s_addr[10], 32'h0C);
    check("t3_wr1_a",   s_we[12] ? s_addr[12] : 32'hFFFF_FFFF, 32'h64);
    check("t3_wr1_d",   s_wd[12], 32'hA0A0_0003);
    check("t3_done13",  32'(s_done[13]), 32'd1);

    // 4: single word into the I/O output register
    ld(0, 8'd0, 32'h1234_5678);
    run(0, 32'h00, 32'h80, 6'd1, 8, -1);
    check("t4_wr_a",   s_we[4] ? s_addr[4] : 32'hFFFF_FFFF, 32'h80);
    check("t4_nwe",    32'(cnt_we(8)), 32'd1);
    check("t4_port0",  mem1[32], 32'h1234_5678);

    // 5: a second start mid-copy is ignored
    run(0, 32'h00, 32'h90, 6'd3, 20, 3);
    check("t5_rd1_a",  s_addr[5], 32'h04);
    check("t5_wr2_a",  s_we[10] ? s_addr[10] : 32'hFFFF_FFFF, 32'h98);
    check("t5_nwe",    32'(cnt_we(20)), 32'd3);
    check("t5_done11", 32'(s_done[11]), 32'd1);
    check("t5_ndone",  32'(cnt_done(20)), 32'd1);
    check("t5_ram36",  mem1[36], 32'h1234_5678);
    check("t5_ram38",  mem1[38], 32'hA0A0_0002);

    // 6: reset after the second write of a 4-word copy
    for (int i = 48; i < 52; i++) ld(0, 8'(i), 32'hDEAD_0000);
    run(0, 32'h00, 32'hC0, 6'd4, 8, -1);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("t6_busy", 32'(busy1), 32'd0);
    check("t6_req",  32'(b1.bus_req), 32'd0);
    check("t6_addr", b1.addr, 32'd0);
    check("t6_we",   32'(b1.we), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_ram48", mem1[48], 32'h1234_5678);
    check("t6_ram49", mem1[49], 32'hA0A0_0001);
    check("t6_ram50", mem1[50], 32'hDEAD_0000);
    run(0, 32'h08, 32'hC8, 6'd2, 10, -1);
    check("t6_rerun_a",  s_we[4] ? s_addr[4] : 32'hFFFF_FFFF, 32'hC8);
    check("t6_rerun_d",  s_wd[7], 32'hA0A0_0003);
    check("t6_done8",    32'(s_done[8]), 32'd1);

    // 7: RD_LAT=3 with source address wrapping through zero
    ld(1, 8'd255, 32'hCAFE_F00D);
    ld(1, 8'd0,   32'h0BAD_BEEF);
    run(1, 32'hFFFF_FFFC, 32'h40, 6'd2, 16, -1);
    check("t7_rd0_a",   s_addr[2], 32'hFFFF_FFFC);
    check("t7_wait_a",  s_addr[5], 32'hFFFF_FFFC);
    check("t7_we5",     32'(s_we[5]), 32'd0);
    check("t7_wr0_a",   s_we[6] ? s_addr[6] : 32'hFFFF_FFFF, 32'h40);
    check("t7_wr0_d",   s_wd[6], 32'hCAFE_F00D);
    check("t7_rd1_a",   s_req[7] ? s_addr[7] : 32'hFFFF_FFFF, 32'h0);
    check("t7_wr1_a",   s_we[11] ? s_addr[11] : 32'hFFFF_FFFF, 32'h44);
    check("t7_wr1_d",   s_wd[11], 32'h0BAD_BEEF);
    check("t7_nwe",     32'(cnt_we(16)), 32'd2);
    check("t7_done12",  32'(s_done[12]), 32'd1);
    check("t7_ram16",   mem2[16], 32'hCAFE_F00D);
    check("t7_ram17",   mem2[17], 32'h0BAD_BEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
